// File: rtl/int_service_seq_pkg.sv
// Shared definitions for the interrupt service sequencer.
//   state_t   : FSM encoding (IDLE/ENTER/VECTOR/RETURN)
//   lvl_mask  : mask covering every level at or below a given level
//   vec_addr  : vector address of a level (caller truncates to AW)
package int_service_seq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam int NLVL = 4;

  // (2<<lvl)-1 : levels 0..lvl set
  function automatic logic [NLVL-1:0] lvl_mask(input logic [1:0] lvl);
    return 4'((5'd2 << lvl) - 5'd1);
  endfunction

  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [1:0]  lvl);
    return base + 32'(lvl) * stride;
  endfunction
endpackage

// File: rtl/int_service_seq_if.sv
// Bus between the CPU/interrupt-latch side and the service sequencer.
//   master : CPU/latch side (drives requests, sees controls)
//   slave  : sequencer side
interface int_service_seq_if #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
);
  logic                     in_break;
  logic [1:0]               in_code;
  logic                     in_instr_done;
  logic                     in_eret;
  logic [AW-1:0]            in_pc;
  logic                     in_ie_set;
  logic                     in_ie_clr;
  logic                     in_mask_wr;
  logic [3:0]               in_mask_data;
  logic                     out_IE;
  logic [3:0]               out_INM;
  logic [3:0]               out_IG;
  logic                     out_pc_load;
  logic [AW-1:0]            out_pc_value;
  logic                     out_stall;
  logic [$clog2(DEPTH):0]   out_depth;
  logic                     out_err;

  modport master (
    output in_break, in_code, in_instr_done, in_eret, in_pc,
           in_ie_set, in_ie_clr, in_mask_wr, in_mask_data,
    input  out_IE, out_INM, out_IG, out_pc_load, out_pc_value,
           out_stall, out_depth, out_err
  );

  modport slave (
    input  in_break, in_code, in_instr_done, in_eret, in_pc,
           in_ie_set, in_ie_clr, in_mask_wr, in_mask_data,
    output out_IE, out_INM, out_IG, out_pc_load, out_pc_value,
           out_stall, out_depth, out_err
  );
endinterface

// File: rtl/int_service_seq_ctx_stack.sv
// int_ctx_stack: LIFO of saved interrupt contexts.
//   clk, in_RST (async high, clears pointer only)
//   push/din  : write new top      pop : drop top
//   dout      : current top entry (combinational read)
//   full/empty/depth : occupancy
module int_ctx_stack #(
  parameter int W     = 21,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   in_RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] depth
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] sp;

  // contents are never reset; only the pointer matters
  always_ff @(posedge clk)
    if (push && !full) mem[sp[PW-1:0]] <= din;

  always_ff @(posedge clk or posedge in_RST)
    if (in_RST)                sp <= '0;
    else if (push && !full)    sp <= sp + DW'(1);
    else if (pop && !empty)    sp <= sp - DW'(1);

  assign dout  = mem[PW'(sp - DW'(1))];
  assign full  = (sp == DW'(DEPTH));
  assign empty = (sp == '0);
  assign depth = sp;
endmodule

// File: rtl/int_service_seq.sv
// int_service_seq: CPU-side interrupt entry / nested return sequencer.
//   clk, in_RST (async high)
//   bus (slave): request from the latch, boundary/ERET/PC from the CPU,
//                software EI/DI/mask writes; drives IE, INM, IG pulses,
//                PC redirect, stall, nesting depth and ERET-underflow error.
// Entry: boundary -> ENTER (IG pulse, mask) -> VECTOR (pc_load) -> IDLE.
// Return: ERET -> RETURN (pop, pc_load) -> IDLE.
module int_service_seq
  import int_service_seq_pkg::*;
#(
  parameter int          AW         = 16,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0010,
  parameter bit          NEST_EN    = 1'b1
) (
  input logic              clk,
  input logic              in_RST,
  int_service_seq_if.slave bus
);
  localparam int SW = AW + 5;   // {epc, mask, ie}

  state_t                 state;
  logic [1:0]             lvl;
  logic                   full, empty;
  logic [$clog2(DEPTH):0] depth;
  logic [SW-1:0]          top_ent;
  logic                   take_ret, take_int, push, pop;

  // ERET outranks a simultaneous request
  assign take_ret = bus.in_eret & ~empty;
  assign take_int = bus.in_instr_done & bus.in_break & bus.out_IE & ~full & ~bus.in_eret;
  assign push     = (state == IDLE) & take_int;
  assign pop      = (state == IDLE) & take_ret;

  int_ctx_stack #(.W(SW), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .in_RST(in_RST),
    .push  (push),
    .pop   (pop),
    .din   ({bus.in_pc, bus.out_INM, bus.out_IE}),
    .dout  (top_ent),
    .full  (full),
    .empty (empty),
    .depth (depth)
  );

  assign bus.out_depth = depth;

  // Outputs are set on the edge entering a state so they are visible
  // during that state's cycle.
  always_ff @(posedge clk or posedge in_RST) begin
    if (in_RST) begin
      state            <= IDLE;
      lvl              <= '0;
      bus.out_IE       <= 1'b0;
      bus.out_INM      <= '0;
      bus.out_IG       <= '0;
      bus.out_pc_load  <= 1'b0;
      bus.out_pc_value <= '0;
      bus.out_stall    <= 1'b0;
      bus.out_err      <= 1'b0;
    end else begin
      bus.out_IG      <= '0;
      bus.out_pc_load <= 1'b0;
      bus.out_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (take_ret) begin
            state            <= RETURN;
            bus.out_pc_value <= top_ent[SW-1:5];
            bus.out_INM      <= top_ent[4:1];
            bus.out_IE       <= top_ent[0];
            bus.out_pc_load  <= 1'b1;
            bus.out_stall    <= 1'b1;
          end else if (take_int) begin
            state         <= ENTER;
            lvl           <= bus.in_code;
            bus.out_IG    <= 4'b0001 << bus.in_code;
            bus.out_IE    <= 1'b0;
            bus.out_INM   <= bus.out_INM | lvl_mask(bus.in_code);
            bus.out_stall <= 1'b1;
          end else begin
            if (bus.in_eret) bus.out_err <= 1'b1;  // ERET with nothing to pop
            if (bus.in_mask_wr) bus.out_INM <= bus.in_mask_data;
            if (bus.in_ie_clr)      bus.out_IE <= 1'b0;
            else if (bus.in_ie_set) bus.out_IE <= 1'b1;
          end
        end
        ENTER: begin
          state            <= VECTOR;
          bus.out_pc_load  <= 1'b1;
          bus.out_pc_value <= AW'(vec_addr(VEC_BASE, VEC_STRIDE, lvl));
          bus.out_IE       <= NEST_EN;
        end
        VECTOR, RETURN: begin
          state         <= IDLE;
          bus.out_stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/int_service_seq.md
Name: int_service_seq

Overview:
CPU-side interrupt service sequencer. It consumes the pending-interrupt request (break + 2-bit priority code) from the interrupt latch/priority encoder and drives that block's controls: the per-level grant/clear pulses, the 4-bit mask and the global enable. At instruction boundaries it performs interrupt entry: saves the return PC and context, clears the request, masks equal and lower levels, and redirects the PC to a vector. On ERET it performs the nested return.

Parameters:
AW, 16, PC/address width
DEPTH, 4, nesting stack depth (entries of {epc, mask, ie}); power of 2, ≥2
VEC_BASE, 16'h0100, vector address of level 0
VEC_STRIDE, 16'h0010, vector spacing per level
NEST_EN, 1, 1 = IE re-enabled after entry so a higher level may preempt; 0 = IE stays 0 until ERET

Ports:
clk  in  1  system clock, rising edge
in_RST  in  1  reset
in_break  in  1  pending, unmasked, enabled request
in_code  in  2  level of the highest pending request (3 = highest)
in_instr_done  in  1  instruction boundary; interrupt may be taken
in_eret  in  1  ERET retiring this cycle
in_pc  in  AW  PC of the next instruction (saved as EPC)
in_ie_set  in  1  software EI
in_ie_clr  in  1  software DI
in_mask_wr  in  1  software mask write
in_mask_data  in  4  mask value
out_IE  out  1  global enable to the interrupt latch
out_INM  out  4  per-level mask (1 = masked)
out_IG  out  4  grant/clear pulses, one-hot, registered, glitch-free
out_pc_load  out  1  1-cycle PC redirect strobe
out_pc_value  out  AW  redirect target
out_stall  out  1  hold the pipeline
out_depth  out  $clog2(DEPTH)+1  current nesting depth
out_err  out  1  1-cycle pulse: ERET with empty stack

Behaviour:
- Reset is in_RST: asynchronous, active-high. On reset: state=IDLE, out_IE=0, out_INM=0, out_IG=0, out_pc_load=0, out_pc_value=0, out_stall=0, out_depth=0, out_err=0, stack pointer=0. Stack contents are don't-care. Reset mid-sequence aborts immediately; no pulse is completed.
- All outputs are registered.
- FSM states: IDLE, ENTER, VECTOR, RETURN.
- IDLE, priority high→low:
  - in_eret with depth>0 → RETURN.
  - in_eret with depth=0 → out_err=1 for 1 cycle; stay IDLE.
  - in_instr_done & in_break & out_IE & depth<DEPTH → ENTER. Latch lvl=in_code. Push {in_pc, out_INM, out_IE}.
  - Otherwise apply software writes: in_mask_wr loads out_INM. in_ie_clr clears out_IE, in_ie_set sets it; clr wins if both are asserted.
  - Software writes arriving in the same cycle as a taken ERET or entry are dropped.
  - While depth=DEPTH, requests are held off (not lost, since the latch keeps them). out_stall=0.
- ENTER (1 cycle):
  - out_IG[lvl]=1, all other bits 0.
  - out_IE=0.
  - out_INM ← out_INM | ((2<<lvl)-1), which masks levels ≤ lvl.
  - depth+1; out_stall=1. Next state VECTOR.
- VECTOR (1 cycle):
  - out_IG=0, giving an exactly 1-cycle grant pulse.
  - out_pc_load=1; out_pc_value = VEC_BASE + lvl*VEC_STRIDE, truncated to AW.
  - out_IE ← NEST_EN; out_stall=1. Next state IDLE.
- RETURN (1 cycle):
  - Pop: out_INM ← saved mask, out_IE ← saved ie.
  - out_pc_load=1; out_pc_value ← saved epc.
  - depth−1; out_stall=1. Next state IDLE.
- Simultaneous ERET and break at a boundary: ERET wins. The interrupt is retaken after restore if still pending and unmasked (earliest: second cycle after RETURN).
- in_code is only sampled on the IDLE→ENTER transition; later changes are ignored.
- Latency: boundary cycle → IG pulse at +1 → pc_load at +2. ERET → pc_load at +1.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ENTER=2'd1, VECTOR=2'd2, RETURN=2'd3)
  - level-to-mask function
  - vector-address function
- One natural sub-module, int_ctx_stack: synchronous LIFO of width AW+5, with push/pop, full/empty, depth, and async clear of the pointer on in_RST.

Test Plan:
1. Reset, EI, in_break=1, in_code=2, in_instr_done, in_pc=16'h0042 → IG=4'b0100 for exactly 1 cycle at +1. pc_load with value 16'h0120 at +2. INM=4'b0111, IE=1, depth=1.
2. Preemption: in level-1 handler (INM=4'b0011), a level-3 request → IG=4'b1000, pc 16'h0130, INM=4'b1111, depth=2. Two ERETs → pc values pop in LIFO order. INM ends at 4'b0011, then 4'b0000; depth ends at 0.
3. Same-level/lower request while masked: with in_break=0 from the latch, no entry. Force in_break=1 with IE=0 → no entry, outputs unchanged.
4. Stack full (DEPTH=4, four nested entries) plus a fifth request → no IG, depth stays 4. After one ERET, the request is taken.
5. ERET and break in the same boundary cycle → RETURN first, IG asserted no earlier than 2 cycles later. ERET at depth 0 → out_err 1-cycle pulse, no pc_load.
6. Assert in_RST during ENTER (IG high) → IG, IE, INM, depth all 0 asynchronously. FSM in IDLE after release, and no pc_load occurs.
